// File: rtl/ssd_pkg.sv
// ssd_pkg: shared types and constants for the seven-segment scan capture path
package ssd_pkg;
    localparam logic [7:0] BLANK_PATTERN = 8'hFF;
    localparam logic [3:0] ANODE_NONE    = 4'b1111;
    localparam int         NUM_DIGITS    = 4;
    typedef logic [7:0] seg_pat_t;
    typedef logic [3:0] anode_t;
    // ST_ prefix keeps the state names clear of the SETTLE parameter in the top
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_t;
endpackage

// File: rtl/ssd_anode_classify.sv
// ssd_anode_classify: sorts an active-low anode pattern into valid/blank/illegal and a digit index
module ssd_anode_classify
    import ssd_pkg::*;
(
    input  anode_t     seg_i,
    output logic       valid_o,
    output logic       blank_o,
    output logic       illegal_o,
    output logic [1:0] idx_o
);
    // exactly one low anode selects a digit; all-high is blank; anything else is illegal
    always_comb begin
        valid_o   = (seg_i == 4'b1110) || (seg_i == 4'b1101) || (seg_i == 4'b1011) || (seg_i == 4'b0111);
        blank_o   = seg_i == ANODE_NONE;
        illegal_o = !valid_o && !blank_o;
        idx_o     = !seg_i[0] ? 2'd0 : !seg_i[1] ? 2'd1 : !seg_i[2] ? 2'd2 : 2'd3;
    end
endmodule

// File: rtl/ssd_scan_capture.sv
// ssd_scan_capture: rebuilds the four digit patterns from a multiplexed seven-segment bus
module ssd_scan_capture
    import ssd_pkg::*;
#(
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 1000000,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] seven,
    input  logic [3:0] segment,
    output logic [7:0] disp0,
    output logic [7:0] disp1,
    output logic [7:0] disp2,
    output logic [7:0] disp3,
    output logic       frame_valid,
    output logic       stale,
    output logic       err
);
    localparam logic [7:0]    SETTLE_N = 8'(SETTLE);
    localparam logic [CW-1:0] TO_MAX   = CW'(TIMEOUT);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

    anode_t                s_seg_q, p_seg_q;
    seg_pat_t              s_sev_q, p_sev_q;
    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  same, valid, blank, illegal, acc, to_hit;
    logic [1:0]            idx;
    seg_pat_t              shadow_q [NUM_DIGITS];
    seg_pat_t              disp_q   [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] seen_q, seen_d;
    logic [CW-1:0]         to_q, to_d;
    logic                  fv_q, stale_q, err_q;

    // register the bus once, and keep the previous sample for the stability comparison
    always_ff @(posedge clk) begin
        if (rst) begin
            s_seg_q <= ANODE_NONE;
            s_sev_q <= BLANK_PATTERN;
            p_seg_q <= ANODE_NONE;
            p_sev_q <= BLANK_PATTERN;
        end else begin
            s_seg_q <= segment;
            s_sev_q <= seven;
            p_seg_q <= s_seg_q;
            p_sev_q <= s_sev_q;
        end
    end

    assign same = {s_seg_q, s_sev_q} == {p_seg_q, p_sev_q};

    ssd_anode_classify u_classify (
        .seg_i     (s_seg_q),
        .valid_o   (valid),
        .blank_o   (blank),
        .illegal_o (illegal),
        .idx_o     (idx)
    );

    // settle state machine register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // any change of sample restarts the settle run; an unchanged sample in HOLD is ignored
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (blank || illegal) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (state_q == ST_IDLE || !same) begin
            state_d = ST_SETTLE;
            cnt_d   = 8'd1;
        end else if (state_q == ST_SETTLE) begin
            cnt_d   = cnt_q + 8'd1;
            state_d = (cnt_d == SETTLE_N) ? ST_HOLD : ST_SETTLE;
        end
    end

    // a digit is accepted on the single cycle the settle run completes
    always_comb begin
        acc = valid && (state_q == ST_SETTLE) && (state_d == ST_HOLD);
    end

    // timeout counting and seen-mask update; an accept overrides a coincident timeout
    always_comb begin
        to_hit = !acc && (to_q == TO_LAST);
        to_d   = acc ? '0 : (to_q == TO_MAX) ? to_q : to_q + CW'(1);
        seen_d = ((&seen_q || to_hit) ? '0 : seen_q) | (acc ? NUM_DIGITS'(1) << idx : '0);
    end

    // shadow capture, atomic frame publish and health flags
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '{default: BLANK_PATTERN};
            disp_q   <= '{default: BLANK_PATTERN};
            seen_q   <= '0;
            to_q     <= '0;
            fv_q     <= 1'b0;
            stale_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            seen_q  <= seen_d;
            to_q    <= to_d;
            fv_q    <= &seen_q;
            stale_q <= &seen_q ? 1'b0 : (stale_q | to_hit);
            err_q   <= err_q | illegal;
            if (acc) shadow_q[idx] <= s_sev_q;
            if (&seen_q) disp_q <= shadow_q;
        end
    end

    assign disp0       = disp_q[0];
    assign disp1       = disp_q[1];
    assign disp2       = disp_q[2];
    assign disp3       = disp_q[3];
    assign frame_valid = fv_q;
    assign stale       = stale_q;
    assign err         = err_q;
endmodule

// File: tb/tb_ssd_scan_capture.sv
// tb_ssd_scan_capture: directed and randomized scans checked against a rule-level model
module tb_ssd_scan_capture;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] seven = 8'hFF;
    logic [3:0] segment = 4'hF;
    logic [7:0] disp0, disp1, disp2, disp3;
    logic       frame_valid, stale, err;

    int checks = 0;
    int failures = 0;
    int fv_cnt = 0;

    logic [3:0]  m_seg;
    logic [7:0]  m_sev;
    logic [11:0] m_last;
    int          m_rl, m_idle;
    logic [7:0]  m_shadow [4];
    logic [7:0]  m_disp [4];
    logic [3:0]  m_seen;
    logic        m_fv, m_stale, m_err;

    ssd_scan_capture #(.SETTLE(SETTLE), .TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .rst         (rst),
        .seven       (seven),
        .segment     (segment),
        .disp0       (disp0),
        .disp1       (disp1),
        .disp2       (disp2),
        .disp3       (disp3),
        .frame_valid (frame_valid),
        .stale       (stale),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // rule-level model: run length of identical registered samples, digit set, idle-cycle count
    task automatic model_step();
        int  idx;
        bit  onehot, acc, full, hit;
        if (rst) begin
            m_seg = 4'hF; m_sev = 8'hFF; m_last = 12'hFFF; m_rl = 0; m_idle = 0;
            for (int i = 0; i < 4; i++) begin m_shadow[i] = 8'hFF; m_disp[i] = 8'hFF; end
            m_seen = 4'h0; m_fv = 1'b0; m_stale = 1'b0; m_err = 1'b0;
            return;
        end
        onehot = $countones(~m_seg) == 1;
        idx = 0;
        for (int i = 0; i < 4; i++) if (!m_seg[i]) idx = i;
        m_rl = ({m_seg, m_sev} == m_last) ? ((m_rl <= SETTLE) ? m_rl + 1 : m_rl) : 1;
        acc  = onehot && (m_rl == SETTLE);
        full = m_seen == 4'hF;
        hit  = !acc && (m_idle == TIMEOUT - 1);
        m_idle = acc ? 0 : (m_idle < TIMEOUT ? m_idle + 1 : m_idle);
        m_fv = full;
        if (full) begin
            for (int i = 0; i < 4; i++) m_disp[i] = m_shadow[i];
            m_stale = 1'b0;
        end else if (hit) m_stale = 1'b1;
        if (full || hit) m_seen = 4'h0;
        if (acc) begin m_seen[idx] = 1'b1; m_shadow[idx] = m_sev; end
        if (!onehot && m_seg != 4'hF) m_err = 1'b1;
        m_last = {m_seg, m_sev};
        m_seg = segment;
        m_sev = seven;
    endtask

    task automatic tick(input logic [3:0] an, input logic [7:0] pat, input logic r = 1'b0);
        segment = an; seven = pat; rst = r;
        @(posedge clk);
        model_step();
        #1;
        if (frame_valid === 1'b1) fv_cnt++;
        check("disp", {disp3, disp2, disp1, disp0}, {m_disp[3], m_disp[2], m_disp[1], m_disp[0]});
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("stale", 32'(stale), 32'(m_stale));
        check("err", 32'(err), 32'(m_err));
    endtask

    task automatic dwell(input logic [3:0] an, input logic [7:0] pat, input int n);
        for (int k = 0; k < n; k++) tick(an, pat);
    endtask

    task automatic digit(input int d, input logic [7:0] pat, input int n);
        logic [3:0] an;
        an = ~(4'b0001 << d);
        dwell(an, pat, n);
    endtask

    task automatic scan(input logic [7:0] p0, p1, p2, p3, input int n);
        digit(0, p0, n); digit(1, p1, n); digit(2, p2, n); digit(3, p3, n);
    endtask

    function automatic logic [31:0] disps();
        return {disp3, disp2, disp1, disp0};
    endfunction

    initial begin
        logic [7:0] pool [8];
        logic [3:0] bad  [4];
        pool = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h00, 8'hFF};
        bad  = '{4'b0000, 4'b0011, 4'b1100, 4'b0101};
        repeat (3) tick(4'hF, 8'hFF, 1'b1);
        check("rst_disp", disps(), 32'hFFFF_FFFF);
        check("rst_flags", {29'd0, frame_valid, stale, err}, 32'd0);

        fv_cnt = 0;
        scan(8'hC0, 8'hF9, 8'hA4, 8'hB0, 10);
        dwell(4'hF, 8'hFF, 6);
        check("rr_frames", fv_cnt, 1);
        check("rr_disp", disps(), 32'hB0A4_F9C0);
        check("rr_health", {30'd0, stale, err}, 32'd0);

        fv_cnt = 0;
        digit(0, 8'h92, 6); digit(0, 8'h00, 3); digit(0, 8'h92, 6);
        digit(1, 8'hF9, 10); digit(2, 8'hA4, 10); digit(3, 8'hB0, 10);
        dwell(4'hF, 8'hFF, 6);
        check("glitch_frames", fv_cnt, 1);
        check("glitch_disp", disps(), 32'hB0A4_F992);

        fv_cnt = 0;
        digit(0, 8'hC0, 10); tick(4'b0000, 8'hC0); digit(1, 8'hF9, 10);
        digit(2, 8'hA4, 10); digit(3, 8'hB0, 10);
        dwell(4'hF, 8'hFF, 6);
        check("illegal_err", 32'(err), 32'd1);
        check("illegal_disp", disps(), 32'hB0A4_F9C0);
        scan(8'h88, 8'h83, 8'hC6, 8'hA1, 10);
        dwell(4'hF, 8'hFF, 6);
        check("illegal_frames", fv_cnt, 2);
        check("err_sticky", 32'(err), 32'd1);

        fv_cnt = 0;
        digit(0, 8'h11, 10); digit(1, 8'h22, 10); digit(2, 8'h33, 10);
        dwell(4'hF, 8'hFF, 60);
        check("to_stale", 32'(stale), 32'd1);
        check("to_frames", fv_cnt, 0);
        check("to_disp", disps(), 32'hA1C6_8388);
        scan(8'h44, 8'h55, 8'h66, 8'h77, 10);
        dwell(4'hF, 8'hFF, 6);
        check("to_recover_frames", fv_cnt, 1);
        check("to_recover_stale", 32'(stale), 32'd0);
        check("to_recover_disp", disps(), 32'h7766_5544);

        fv_cnt = 0;
        digit(0, 8'hC0, 10); digit(1, 8'hF9, 10); digit(2, 8'hA4, 10);
        digit(1, 8'h99, 10); digit(3, 8'hB0, 10);
        dwell(4'hF, 8'hFF, 6);
        check("rewrite_frames", fv_cnt, 1);
        check("rewrite_disp", disps(), 32'hB0A4_99C0);

        fv_cnt = 0;
        digit(0, 8'h12, 10); digit(1, 8'h34, 10); digit(2, 8'h56, 10);
        tick(4'hF, 8'hFF, 1'b1);
        check("midrst_disp", disps(), 32'hFFFF_FFFF);
        check("midrst_flags", {29'd0, frame_valid, stale, err}, 32'd0);
        digit(3, 8'h78, 10);
        dwell(4'hF, 8'hFF, 6);
        check("midrst_noframe", fv_cnt, 0);
        scan(8'h12, 8'h34, 8'h56, 8'h78, 10);
        dwell(4'hF, 8'hFF, 6);
        check("midrst_frames", fv_cnt, 1);
        check("midrst_disp2", disps(), 32'h7856_3412);

        for (int it = 0; it < 400; it++) begin
            int         r, n;
            logic [3:0] an;
            logic [7:0] pat;
            r   = $urandom_range(0, 39);
            n   = $urandom_range(1, 12);
            pat = ($urandom_range(0, 3) == 0) ? 8'($urandom) : pool[$urandom_range(0, 7)];
            an  = ~(4'b0001 << $urandom_range(0, 3));
            if (r < 30) dwell(an, pat, n);
            else if (r < 35) dwell(4'hF, 8'hFF, n);
            else if (r < 37) dwell(4'hF, 8'hFF, 55);
            else if (r < 39) dwell(bad[$urandom_range(0, 3)], pat, $urandom_range(1, 3));
            else tick(an, pat, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
